imm_decode_stage: RTL
=====================

# imm_decode_stage

Registered decode stage that owns the core's single shared `imm_extend_unit`. It accepts fetched instructions over a valid/ready handshake and decodes the opcode into the `immediate_type_e` select that drives the extend unit. It captures the extended immediate, immediate class, PC-relative target and an illegal-opcode flag into a 2-entry skid buffer. The block sits between fetch and execute, so execute sees a clean registered immediate with full-throughput backpressure.

## Interface
- XLEN, riscv_pkg::XLEN (32): data and PC width.
- CNT_W, 16: width of the saturating illegal-instruction counter.

- clk_i  in  1  core clock, all state on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  discard all buffered entries and any same-cycle input.
- in_valid_i  in  1  fetch offers an instruction.
- in_ready_o  out  1  stage can accept.
- in_instr_i  in  32  instruction word.
- in_pc_i  in  XLEN  instruction PC.
- imm_source_o  out  immediate_type_e  select to `imm_extend_unit`.
- imm_instr_o  out  XLEN  instruction to `imm_extend_unit`; equals in_instr_i.
- imm_extended_i  in  XLEN  result from `imm_extend_unit`.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  execute consumes the head entry.
- out_imm_o  out  XLEN  extended immediate.
- out_imm_type_o  out  immediate_type_e  immediate class of the head entry.
- out_has_imm_o  out  1  instruction carries an immediate.
- out_pc_o  out  XLEN  PC of the head entry.
- out_target_o  out  XLEN  out_pc_o + out_imm_o for B, J and AUIPC; otherwise 0.
- out_illegal_o  out  1  unrecognised opcode, or instr[1:0] ≠ 2'b11.
- illegal_cnt_o  out  CNT_W  accepted illegal instructions, saturating.

## Operation

**Opcode decode.** The decode is combinational on in_instr_i[6:0]:
- 0000011, 0010011, 1100111 → IMM_I
- 0100011 → IMM_S
- 1100011 → IMM_B
- 0110111, 0010111 → IMM_U
- 1101111 → IMM_J
- 0110011, 0001111, 1110011 → has_imm=0. The select is IMM_I, but the captured imm is forced to 0.
- Any other opcode, or instr[1:0] ≠ 11 → illegal=1, has_imm=0, imm=0, target=0. The select is IMM_I.

**Capture.** Accept occurs when in_valid_i && in_ready_o && !flush_i. On accept, the block captures:
- imm_extended_i (or 0, per the decode rules above)
- the immediate type and has_imm
- the PC
- the target, computed as in_pc_i + imm modulo 2^XLEN, no overflow flag
- the illegal flag

**Skid buffer.** The buffer has a main (head) entry and a skid entry.
- in_ready_o = !skid_valid. It is registered state only, with no combinational path from out_ready_i.
- States:
  - EMPTY: no entries valid.
  - ONE: head entry valid.
  - TWO: head and skid entries valid.
- Transitions:
  - EMPTY: accept → ONE.
  - ONE: accept with no pop → TWO. Pop with no accept → EMPTY. Accept and pop together → ONE, with the new data in the head.
  - TWO: pop → ONE, with the skid entry moving to the head. Accept is impossible in TWO.
- Order is strictly FIFO.
- The head data registers change only on accept or pop. They hold stable while out_valid_o && !out_ready_i.

**Flush.** flush_i takes precedence over everything else.
- Next state is EMPTY.
- Same-cycle input is dropped.
- A same-cycle pop still counts as a handshake from execute, but the data is discarded.
- The illegal counter does not count flushed-input instructions.

**Illegal counter.** illegal_cnt_o increments by 1 on each accept with illegal=1. It saturates at 2^CNT_W−1 and never wraps. Only reset clears it.

## Timing
- Reset (async assert, sync release):
  - state EMPTY, out_valid_o=0, in_ready_o=1
  - out_imm_o, out_pc_o and out_target_o = 0
  - out_imm_type_o=IMM_I, out_has_imm_o=0, out_illegal_o=0
  - illegal_cnt_o=0
  - Reset mid-operation discards all entries immediately.
- Latency is 1 cycle: when accepted at edge N, the entry is visible with out_valid_o=1 after edge N.
- Throughput is 1 instruction/cycle while out_ready_i=1.
- imm_source_o and imm_instr_o are purely combinational from in_instr_i. Extend-unit propagation plus the adder must fit in one cycle.
- Once out_valid_o is asserted, it stays high until a pop or a flush.

## Test plan
- **I-type accept.** 0xFFF00093 at PC 0x100, out_ready_i=1 → after 1 cycle: out_imm_o=0xFFFFFFFF, type IMM_I, has_imm=1, target=0, illegal=0.
- **Branch target.** beq 0xFE000CE3 at PC 0x200 → out_imm_o=0xFFFFFFF8, IMM_B, out_target_o=0x1F8. Also PC 0xFFFFFFFC with jal 0x0080006F → imm 0x8, target 0x4 (wrap).
- **Backpressure.**
  - Hold out_ready_i=0 and send lui 0x12345537 then jal 0x0080006F → state TWO, in_ready_o=0.
  - Outputs stay fixed at imm 0x12345000.
  - Release → jal is presented next with imm 0x8, then EMPTY.
  - No loss or duplication.
- **Illegal opcode.**
  - 0x00000000 → out_illegal_o=1, imm 0, illegal_cnt_o 0→1.
  - Preload the counter near saturation via 0xFFFF illegal accepts, then one more → stays 0xFFFF.
- **Flush.** Flush in TWO with in_valid_i=1 → next cycle out_valid_o=0, in_ready_o=1, the offered instruction is dropped, the counter is unchanged.
- **Reset mid-operation.** Assert rst_ni=0 in TWO, asynchronously mid-cycle → all outputs are at their reset values before the next edge. After release, the first accept behaves as from EMPTY.

Source files
------------

// File: rtl/imm_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : imm_decode_stage
// Summary  : Registered opcode decode around the shared immediate extend unit,
//            feeding execute through a 2-entry skid buffer.
//            Immediate class encoding: I=0, S=1, B=2, U=3, J=4.
// Revision : 1.0  initial release
// ============================================================================
module imm_decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      in_instr_i,
    input  logic [XLEN-1:0]  in_pc_i,
    output logic [2:0]       imm_source_o,
    output logic [XLEN-1:0]  imm_instr_o,
    input  logic [XLEN-1:0]  imm_extended_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  out_imm_o,
    output logic [2:0]       out_imm_type_o,
    output logic             out_has_imm_o,
    output logic [XLEN-1:0]  out_pc_o,
    output logic [XLEN-1:0]  out_target_o,
    output logic             out_illegal_o,
    output logic [CNT_W-1:0] illegal_cnt_o
);

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      imm_type;
        logic            has_imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
        logic            illegal;
    } entry_t;

    logic [1:0]       state_q, state_d;
    entry_t           head_q, head_d;
    entry_t           skid_q, skid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic   dec_has_imm;
    logic   dec_illegal;
    logic   dec_pc_rel;
    logic   accept;
    logic   pop;
    entry_t new_entry;

    always_comb begin
        imm_source_o = IMM_I;
        dec_has_imm  = 1'b1;
        dec_illegal  = 1'b0;
        dec_pc_rel   = 1'b0;
        case (in_instr_i[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: imm_source_o = IMM_I;
            7'b0100011: imm_source_o = IMM_S;
            7'b1100011: begin
                imm_source_o = IMM_B;
                dec_pc_rel   = 1'b1;
            end
            7'b0110111: imm_source_o = IMM_U;
            7'b0010111: begin
                imm_source_o = IMM_U;
                dec_pc_rel   = 1'b1;
            end
            7'b1101111: begin
                imm_source_o = IMM_J;
                dec_pc_rel   = 1'b1;
            end
            7'b0110011, 7'b0001111, 7'b1110011: dec_has_imm = 1'b0;
            default: begin
                dec_has_imm = 1'b0;
                dec_illegal = 1'b1;
            end
        endcase
        // A non-32-bit encoding overrides whatever the opcode field decoded to
        if (in_instr_i[1:0] != 2'b11) begin
            imm_source_o = IMM_I;
            dec_has_imm  = 1'b0;
            dec_illegal  = 1'b1;
            dec_pc_rel   = 1'b0;
        end
    end

    assign imm_instr_o = XLEN'(in_instr_i);

    always_comb begin
        new_entry.imm      = dec_has_imm ? imm_extended_i : '0;
        new_entry.imm_type = imm_source_o;
        new_entry.has_imm  = dec_has_imm;
        new_entry.pc       = in_pc_i;
        new_entry.target   = dec_pc_rel ? (in_pc_i + new_entry.imm) : '0;
        new_entry.illegal  = dec_illegal;
    end

    assign in_ready_o  = (state_q != ST_TWO);
    assign out_valid_o = (state_q != ST_EMPTY);
    assign accept      = in_valid_i && in_ready_o && !flush_i;
    assign pop         = out_valid_o && out_ready_i;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q;
        if (accept && dec_illegal && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        head_d  = new_entry;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        head_d = new_entry;
                    end else if (accept) begin
                        skid_d  = new_entry;
                        state_d = ST_TWO;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        head_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_imm_o      = head_q.imm;
    assign out_imm_type_o = head_q.imm_type;
    assign out_has_imm_o  = head_q.has_imm;
    assign out_pc_o       = head_q.pc;
    assign out_target_o   = head_q.target;
    assign out_illegal_o  = head_q.illegal;
    assign illegal_cnt_o  = cnt_q;

endmodule
`default_nettype wire
